// File: rtl/memory_arbiter.sv
// ============================================================================
//  Module      : memory_arbiter
//  Description : Serialises instruction-fetch and data requests onto one
//                single-ported RAM, data first, with a timeout/error trap.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DREQ = 3'd1;
  localparam logic [2:0] S_IREQ = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] K_IRD = 2'd0;
  localparam logic [1:0] K_DRD = 2'd1;
  localparam logic [1:0] K_DWR = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  // Last count before expiry: the TIMEOUT-th waiting cycle is the expiry cycle.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [1:0]      kind_q, kind_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     store_q, store_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [31:0]     iload_q, iload_d;
  logic [31:0]     dload_q, dload_d;

  logic in_req, access, expire;

  assign in_req = (state_q == S_DREQ) || (state_q == S_IREQ);
  assign access = (ramstate == RAM_ACCESS);
  assign expire = (wdog_q == WD_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      kind_q  <= K_IRD;
      addr_q  <= '0;
      store_q <= '0;
      wdog_q  <= '0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wdog_q  <= wdog_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dWEN || dREN) state_d = S_DREQ;
        else if (iREN)    state_d = S_IREQ;
      end
      S_DREQ, S_IREQ: begin
        if (access)                                state_d = S_DONE;
        else if ((ramstate == RAM_ERROR) || expire) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    kind_d  = kind_q;
    addr_d  = addr_q;
    store_d = store_q;
    iload_d = iload_q;
    dload_d = dload_q;
    wdog_d  = '0;
    if (state_q == S_IDLE) begin
      if (dWEN) begin
        kind_d  = K_DWR;
        addr_d  = daddr;
        store_d = dstore;
      end else if (dREN) begin
        kind_d  = K_DRD;
        addr_d  = daddr;
        store_d = '0;
      end else if (iREN) begin
        kind_d  = K_IRD;
        addr_d  = iaddr;
        store_d = '0;
      end
    end
    if (in_req) begin
      if (access) begin
        if (kind_q == K_IRD)      iload_d = ramload;
        else if (kind_q == K_DRD) dload_d = ramload;
      end else begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end
  end

  always_comb begin
    ihit     = (state_q == S_DONE) && (kind_q == K_IRD);
    dhit     = (state_q == S_DONE) && (kind_q != K_IRD);
    memerr   = (state_q == S_ERR);
    ramREN   = in_req && (kind_q != K_DWR);
    ramWEN   = in_req && (kind_q == K_DWR);
    ramaddr  = in_req ? addr_q  : 32'd0;
    ramstore = in_req ? store_q : 32'd0;
  end

  assign iload = iload_q;
  assign dload = dload_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Directed scenarios plus randomized traffic against a
//                transaction-level model of the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

  localparam int TO = 4;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_cmp = 0;
  int n_err = 0;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  // Transaction-level model: phase 0 idle, 1 waiting on RAM, 2 hit, 3 dead.
  // Kind 0 instruction read, 1 data read, 2 data write.
  int          m_phase, m_kind, m_waits;
  logic [31:0] m_addr, m_data, m_iload, m_dload;

  task automatic model_reset();
    m_phase = 0; m_kind = 0; m_waits = 0;
    m_addr = 0; m_data = 0; m_iload = 0; m_dload = 0;
  endtask

  task automatic model_step();
    if (!nRST) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          if (dWEN || dREN) begin
            m_phase = 1; m_waits = 0; m_addr = daddr;
            m_kind  = dWEN ? 2 : 1;
            m_data  = dstore;
          end else if (iREN) begin
            m_phase = 1; m_waits = 0; m_addr = iaddr; m_kind = 0;
          end
        end
        1: begin
          if (ramstate == ACCESS) begin
            m_phase = 2;
            if (m_kind == 0) m_iload = ramload;
            if (m_kind == 1) m_dload = ramload;
          end else if (ramstate == ERROR) begin
            m_phase = 3;
          end else begin
            m_waits++;
            if (m_waits >= TO) m_phase = 3;
          end
        end
        2: m_phase = 0;
        default: m_phase = 3;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit req;
    req = (m_phase == 1);
    chk("ihit",   32'(ihit),   32'((m_phase == 2) && (m_kind == 0)));
    chk("dhit",   32'(dhit),   32'((m_phase == 2) && (m_kind != 0)));
    chk("memerr", 32'(memerr), 32'(m_phase == 3));
    chk("ramREN", 32'(ramREN), 32'(req && (m_kind != 2)));
    chk("ramWEN", 32'(ramWEN), 32'(req && (m_kind == 2)));
    chk("ramaddr", ramaddr, req ? m_addr : 32'd0);
    if (!req)           chk("ramstore_idle", ramstore, 32'd0);
    else if (m_kind == 2) chk("ramstore", ramstore, m_data);
    chk("iload", iload, m_iload);
    chk("dload", dload, m_dload);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
  endtask

  // Asynchronous assertion away from the edge, one clocked cycle in reset, release.
  task automatic do_reset();
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    model_reset();
    #3;
    compare_all();
    tick();
    tick();
    nRST = 1'b1;
    chk("rst_ihit",   32'(ihit),   32'd0);
    chk("rst_memerr", 32'(memerr), 32'd0);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_iload",  iload,       32'd0);

    // Simple fetch
    iREN = 1; iaddr = 32'h40;
    tick();
    chk("fetch_ramREN",  32'(ramREN), 32'd1);
    chk("fetch_ramaddr", ramaddr,     32'h40);
    ramstate = ACCESS; ramload = 32'h8C010004;
    tick();
    chk("fetch_ihit",  32'(ihit), 32'd1);
    chk("fetch_iload", iload,     32'h8C010004);
    iREN = 0; ramstate = FREE;
    tick();
    chk("fetch_idle_ihit", 32'(ihit), 32'd0);

    // Simultaneous requests: data first, no re-issue during DONE
    iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h100;
    ramstate = ACCESS; ramload = 32'h1111;
    tick();
    chk("sim_d_addr", ramaddr, 32'h100);
    tick();
    chk("sim_dhit",  32'(dhit),  32'd1);
    chk("sim_dload", dload,      32'h1111);
    dREN = 0; ramload = 32'h2222;
    tick();
    chk("sim_done_noreq", 32'(ramREN), 32'd0);
    tick();
    chk("sim_i_addr", ramaddr, 32'h44);
    tick();
    chk("sim_ihit",  32'(ihit), 32'd1);
    chk("sim_iload", iload,     32'h2222);
    iREN = 0; ramstate = FREE;
    tick();

    // Write with three BUSY cycles; ACCESS lands on the watchdog expiry cycle
    dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    tick();
    ramstate = BUSY;
    for (int i = 0; i < 4; i++) begin
      chk("wr_ramWEN",   32'(ramWEN), 32'd1);
      chk("wr_ramstore", ramstore,    32'hDEADBEEF);
      if (i < 3) tick();
      else begin
        ramstate = ACCESS;
        tick();
      end
    end
    chk("wr_dhit",   32'(dhit),   32'd1);
    chk("wr_memerr", 32'(memerr), 32'd0);
    chk("wr_dload",  dload,       32'h1111);
    dWEN = 0; ramstate = FREE;
    tick();

    // Watchdog: stuck BUSY for TO cycles
    dREN = 1; daddr = 32'h300; ramstate = BUSY;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    chk("wd_pre_memerr", 32'(memerr), 32'd0);
    tick();
    chk("wd_memerr", 32'(memerr), 32'd1);
    chk("wd_ramREN", 32'(ramREN), 32'd0);
    dREN = 0; iREN = 1; ramstate = ACCESS;
    tick();
    tick();
    chk("wd_sticky", 32'(memerr), 32'd1);
    chk("wd_noihit", 32'(ihit),   32'd0);
    iREN = 0; ramstate = FREE;
    do_reset();

    // ERROR status on first DREQ cycle
    dREN = 1; daddr = 32'h10;
    tick();
    ramstate = ERROR;
    tick();
    chk("err_memerr", 32'(memerr), 32'd1);
    chk("err_dhit",   32'(dhit),   32'd0);
    dREN = 0; ramstate = FREE;
    do_reset();

    // Reset mid-write
    dWEN = 1; daddr = 32'h400; dstore = 32'h55;
    tick();
    chk("mid_ramWEN", 32'(ramWEN), 32'd1);
    dWEN = 0; ramstate = ACCESS;
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("mid_async_ramWEN", 32'(ramWEN), 32'd0);
    chk("mid_async_addr",   ramaddr,     32'd0);
    tick();
    chk("mid_nodhit", 32'(dhit), 32'd0);
    nRST = 1'b1;
    ramstate = FREE;
    tick();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int r;
      iREN   = 1'($urandom_range(0, 1));
      dREN   = ($urandom_range(0, 3) == 0);
      dWEN   = ($urandom_range(0, 3) == 0);
      iaddr  = $urandom;
      daddr  = $urandom;
      dstore = $urandom;
      ramload = $urandom;
      r = $urandom_range(0, 99);
      ramstate = (r < 40) ? ACCESS : (r < 42) ? ERROR : (r < 70) ? BUSY : FREE;
      if ((m_phase == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
        do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Multi-cycle arbiter between the request unit and the single-ported RAM. It accepts instruction-fetch and data read/write requests, gives data priority, and runs one RAM transaction at a time through a FREE/BUSY/ACCESS/ERROR RAM handshake. It returns one-cycle `ihit`/`dhit` pulses with registered load data, which drive the request unit's hit inputs. A watchdog counter turns a stuck or failing RAM into a sticky error state.

## Interface
- `TIMEOUT`, 255: maximum cycles a transaction may wait in a request state without seeing ACCESS.
- `CLK` input 1: the single clock; all state updates on the rising edge.
- `nRST` input 1: reset, asynchronous and active-low.
- `iREN` input 1: instruction read request (request unit `imemREN`).
- `iaddr` input 32: instruction word address.
- `dREN` input 1: data read request (request unit `dmemREN`).
- `dWEN` input 1: data write request (request unit `dmemWEN`).
- `daddr` input 32: data address.
- `dstore` input 32: data write value.
- `ihit` output 1: one-cycle pulse, instruction transaction complete.
- `dhit` output 1: one-cycle pulse, data transaction complete.
- `iload` output 32: registered instruction word.
- `dload` output 32: registered read data.
- `ramREN` output 1: RAM read enable.
- `ramWEN` output 1: RAM write enable.
- `ramaddr` output 32: RAM address.
- `ramstore` output 32: RAM write data.
- `ramload` input 32: RAM read data, valid when `ramstate` is ACCESS.
- `ramstate` input 2: RAM status. 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
- `memerr` output 1: sticky fault flag.

## Operation
- States and transitions:
  - IDLE: if `dWEN` or `dREN`, go to DREQ. Else if `iREN`, go to IREQ. Else stay.
  - DREQ / IREQ:
    - `ramstate` ACCESS: go to DONE.
    - `ramstate` ERROR, or watchdog expiry: go to ERR.
    - Otherwise (FREE or BUSY): hold.
  - DONE: go to IDLE unconditionally. No new request is sampled in DONE; this absorbs the request the requester is still holding in the hit cycle.
  - ERR: terminal until `nRST`.
- Priority and latching:
  - Data beats instruction when both request in IDLE.
  - `dWEN` beats `dREN` when both are high; the transaction is a write.
  - On the IDLE→DREQ/IREQ edge, the block latches:
    - kind: I-read, D-read or D-write;
    - the selected address;
    - `dstore`, for writes.
  - Requester inputs are ignored after that until IDLE.
- RAM drive:
  - In DREQ and IREQ only, `ramaddr` and `ramstore` come from the latches, and:
    - `ramREN` = 1 for reads;
    - `ramWEN` = 1 for writes.
  - In IDLE, DONE and ERR, `ramREN`, `ramWEN`, `ramaddr` and `ramstore` are all 0.
  - `ramREN` and `ramWEN` are never high together.
- Completion:
  - On the edge leaving a request state with ACCESS, `ramload` is captured into `iload` (I-read) or `dload` (D-read). A D-write leaves `dload` unchanged.
  - In DONE, exactly one of `ihit`/`dhit` is 1, matching the latched kind.
- Load-data hold: `iload`/`dload` hold their value until the next completing read of the same kind.
- Watchdog:
  - Counter width is clog2(TIMEOUT+1).
  - Cleared on entry to a request state; increments each cycle spent in a request state without ACCESS.
  - Expires when the count reaches TIMEOUT.
  - If ACCESS arrives in the expiry cycle, ACCESS wins.
- ERR behaviour:
  - `memerr` = 1.
  - All hits and RAM enables are 0.
  - `iload`/`dload` frozen.

## Timing
- Reset: async assert forces the following from any state, including mid-transaction:
  - state IDLE;
  - `ihit`, `dhit`, `memerr`, `ramREN`, `ramWEN` all 0;
  - `ramaddr`, `ramstore`, `iload`, `dload` all 0;
  - watchdog 0.
  
  The first request is sampled on the first rising edge after deassert.
- Minimum latency: request sampled at edge k, then:
  - request state during cycle k..k+1, and RAM enable is high in that cycle;
  - if ACCESS is seen then, hit is high in cycle k+1..k+2;
  - IDLE from edge k+2.
  
  Best case is 3 cycles request-to-request.
- Each BUSY/FREE cycle in a request state adds one cycle.
- Hits are registered state decodes: glitch-free, exactly one cycle wide.
- Load data is valid in the hit cycle and held afterwards.

## Test plan
- Reset mid-transaction: assert `nRST`=0 while in DREQ with `ramWEN`=1 → RAM enables drop asynchronously, no `dhit`, then IDLE.
- Simple fetch:
  - Stimulus: `iREN`=1, `iaddr`=0x40, RAM ACCESS first cycle with `ramload`=0x8C010004.
  - Response: `ramREN`=1 and `ramaddr`=0x40 for 1 cycle; `ihit` pulse next cycle; `iload`=0x8C010004; 3 cycles total.
- Simultaneous requests:
  - Stimulus: `iREN`=`dREN`=1, `daddr`=0x100, `iaddr`=0x44.
  - Response:
    - data served first;
    - `dhit`, then DONE;
    - IDLE;
    - fetch of 0x44 starts, with `ihit` following.
  - No re-issue of the data read during DONE.
- Write with wait states:
  - Stimulus: `dWEN`=1, `daddr`=0x200, `dstore`=0xDEADBEEF; RAM gives BUSY×3 then ACCESS.
  - Response: `ramWEN`=1 for 4 cycles with stable address/data; `dhit` 1 cycle; `dload` unchanged.
- Watchdog:
  - Stimulus: `TIMEOUT`=4, RAM stuck BUSY.
  - Response: after 4 request cycles, ERR; `memerr`=1 sticky; enables 0; new requests ignored until reset.
- ERROR status:
  - Stimulus: `ramstate`=11 on the first DREQ cycle.
  - Response: ERR next cycle; no `dhit`.
  - Variant: ACCESS on the expiry cycle with `TIMEOUT`=2 → normal `dhit`, no `memerr`.
